// File: rtl/apb4_master_pkg.sv
// Shared types and helpers for the multi-slave APB4 master.
`timescale 1ns/1ps
package apb4_master_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } state_t;

    // Width needed to index n items; never narrower than one bit
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb4_master_nslv_if.sv
// Command, response and APB fabric signals of the multi-slave APB4 master.
// Names are given from the master's point of view.
`timescale 1ns/1ps
interface apb4_master_nslv_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // command side
    logic                           i_valid;
    logic                           o_ready;
    logic [ADDR_WIDTH-1:0]          i_addr;
    logic                           i_rd0_wr1;
    logic [DATA_WIDTH-1:0]          i_wr_data;
    logic [STRB_W-1:0]              i_wr_strb;
    logic [2:0]                     i_prot;

    // response side
    logic                           o_rsp_valid;
    logic [DATA_WIDTH-1:0]          o_rsp_data;
    logic                           o_rsp_err;
    logic                           o_rsp_timeout;

    // APB fabric
    logic [NUM_SLAVES-1:0]          o_psel;
    logic                           o_penable;
    logic                           o_pwrite;
    logic [ADDR_WIDTH-1:0]          o_paddr;
    logic [DATA_WIDTH-1:0]          o_pwdata;
    logic [STRB_W-1:0]              o_pstrb;
    logic [2:0]                     o_pprot;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata;
    logic [NUM_SLAVES-1:0]          i_pready;
    logic [NUM_SLAVES-1:0]          i_pslverr;

    modport master (
        input  i_valid, i_addr, i_rd0_wr1, i_wr_data, i_wr_strb, i_prot,
        output o_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot,
        input  i_prdata, i_pready, i_pslverr
    );

    modport slave (
        output i_valid, i_addr, i_rd0_wr1, i_wr_data, i_wr_strb, i_prot,
        input  o_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot,
        output i_prdata, i_pready, i_pslverr
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible combinationally so the
// sequencer can decode it in the same cycle it pops.
`timescale 1ns/1ps
module apb_cmd_fifo
    import apb4_master_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic i_clk_apb,
    input  logic i_rstn_apb,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int PTR_W = sel_w(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the count gates reads
    always_ff @(posedge i_clk_apb) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb4_master_nslv.sv
// Multi-slave APB4 master: queues commands, decodes each to a select line,
// runs the SETUP/ACCESS handshake with a wait-state timeout and returns one
// registered response per command.
`timescale 1ns/1ps
module apb4_master_nslv
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int SLV_ADDR_LSB = 12,
    parameter int CMD_DEPTH    = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic               i_clk_apb,
    input  logic               i_rstn_apb,
    apb4_master_nslv_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = sel_w(NUM_SLAVES);
    localparam int CNT_W  = sel_w(TIMEOUT + 1);

    // Command word; widths follow this instance's bus parameters
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  rd0_wr1;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [STRB_W-1:0]     wr_strb;
        logic [2:0]            prot;
    } cmd_t;

    state_t                r_state;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic [2:0]            r_pprot;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    cmd_t                  w_in_cmd;
    cmd_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic [SEL_W-1:0]      w_head_idx;
    logic                  w_head_ok;
    logic [NUM_SLAVES-1:0] w_head_psel;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_tmo;
    logic                  w_done;
    logic                  w_advance;

    assign w_in_cmd = '{addr: bus.i_addr, rd0_wr1: bus.i_rd0_wr1, wr_data: bus.i_wr_data,
                        wr_strb: bus.i_wr_strb, prot: bus.i_prot};

    apb_cmd_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_fifo (
        .i_clk_apb  (i_clk_apb),
        .i_rstn_apb (i_rstn_apb),
        .i_push     (bus.i_valid),
        .i_data     (w_in_cmd),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Decode the FIFO head; indices past the last slave become decode errors
    assign w_head_idx  = w_head.addr[SLV_ADDR_LSB +: SEL_W];
    assign w_head_ok   = (int'(w_head_idx) < NUM_SLAVES);
    assign w_head_psel = NUM_SLAVES'(1) << w_head_idx;

    // Return-path mux keyed by the active one-hot select
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_psel[k]) begin
                w_sel_ready = bus.i_pready[k];
                w_sel_err   = bus.i_pslverr[k];
                w_sel_rdata = bus.i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A ready in the same cycle as the limit wins, so timeout requires pready low
    assign w_tmo     = (TIMEOUT != 0) && (r_state == ACCESS) && !w_sel_ready
                       && (r_cnt == CNT_W'(TIMEOUT));
    assign w_done    = (r_state == ACCESS) && (w_sel_ready || w_tmo);
    assign w_advance = (r_state == IDLE) || (r_state == DECERR) || w_done;
    assign w_pop     = w_advance && !w_empty;

    // Sequencer with registered APB outputs, timeout counter and response
    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            r_state       <= IDLE;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= w_tmo || w_sel_err;
                        r_rsp_timeout <= w_tmo;
                        r_rsp_data    <= (!r_pwrite && w_sel_ready && !w_sel_err) ? w_sel_rdata : '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DECERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                end
                default: ;
            endcase
            // Load the next command straight into SETUP so transfers run back-to-back
            if (w_advance) begin
                r_penable <= 1'b0;
                if (!w_empty && w_head_ok) begin
                    r_state  <= SETUP;
                    r_psel   <= w_head_psel;
                    r_pwrite <= w_head.rd0_wr1;
                    r_paddr  <= w_head.addr;
                    r_pwdata <= w_head.rd0_wr1 ? w_head.wr_data : '0;
                    r_pstrb  <= w_head.rd0_wr1 ? w_head.wr_strb : '0;
                    r_pprot  <= w_head.prot;
                end else begin
                    r_state  <= w_empty ? IDLE : DECERR;
                    r_psel   <= '0;
                    r_pwrite <= 1'b0;
                    r_paddr  <= '0;
                    r_pwdata <= '0;
                    r_pstrb  <= '0;
                    r_pprot  <= '0;
                end
            end
        end
    end

    assign bus.o_ready       = !w_full;
    assign bus.o_psel        = r_psel;
    assign bus.o_penable     = r_penable;
    assign bus.o_pwrite      = r_pwrite;
    assign bus.o_paddr       = r_paddr;
    assign bus.o_pwdata      = r_pwdata;
    assign bus.o_pstrb       = r_pstrb;
    assign bus.o_pprot       = r_pprot;
    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_data    = r_rsp_data;
    assign bus.o_rsp_err     = r_rsp_err;
    assign bus.o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb4_master_nslv.sv
// Directed bench for apb4_master_nslv with three slaves and a short timeout.
`timescale 1ns/1ps
module tb_apb4_master_nslv;
    localparam int NS = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    apb4_master_nslv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS)) bus ();

    apb4_master_nslv #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS),
        .SLV_ADDR_LSB(12), .CMD_DEPTH(4), .TIMEOUT(4)
    ) dut (
        .i_clk_apb  (clk),
        .i_rstn_apb (rstn),
        .bus        (bus)
    );

    // Slave behaviour: pready rises in ACCESS cycle number wait_cfg (-1 = never)
    int   wait_cfg [NS];
    logic err_cfg  [NS];
    int   acnt     [NS];

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;
    rsp_t rsp_q[$];
    int   setup_q[$];

    // Slave responder, updated mid-cycle
    initial begin
        bus.i_pready  = '0;
        bus.i_pslverr = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NS; k++) begin
                if (bus.o_psel[k] && bus.o_penable) begin
                    bus.i_pready[k]  = (acnt[k] == wait_cfg[k]);
                    bus.i_pslverr[k] = err_cfg[k] && (acnt[k] == wait_cfg[k]);
                    acnt[k]++;
                end else begin
                    bus.i_pready[k]  = 1'b0;
                    bus.i_pslverr[k] = 1'b0;
                    acnt[k]          = 0;
                end
            end
        end
    end

    // Monitor: SETUP cycle numbers and responses, one line per response
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.o_psel != '0 && !bus.o_penable) setup_q.push_back(cyc);
            if (bus.o_rsp_valid) begin
                rsp_q.push_back('{data: bus.o_rsp_data, err: bus.o_rsp_err, tmo: bus.o_rsp_timeout});
                $display("[%0t] rsp data=%08h err=%0b timeout=%0b", $time,
                         bus.o_rsp_data, bus.o_rsp_err, bus.o_rsp_timeout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        logic ok;
        ok            = 1'b0;
        bus.i_valid   = 1'b1;
        bus.i_addr    = a;
        bus.i_rd0_wr1 = wr;
        bus.i_wr_data = d;
        bus.i_wr_strb = s;
        bus.i_prot    = p;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = bus.o_ready;
            tick();
        end
        chk("push_accept", ok, 1);
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    int   pen;
    int   exp_gap [4];
    logic [31:0] exp_data [5];
    logic exp_err [5];

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_addr    = '0;
        bus.i_rd0_wr1 = 1'b0;
        bus.i_wr_data = '0;
        bus.i_wr_strb = '0;
        bus.i_prot    = '0;
        bus.i_prdata  = {32'h1234_5678, 32'hBBBB_0001, 32'hAAAA_0000};
        for (int k = 0; k < NS; k++) begin
            wait_cfg[k] = 0;
            err_cfg[k]  = 1'b0;
        end
        wait_cfg[2] = 3;

        // Reset state
        tick(); tick();
        chk("rst_ready",   bus.o_ready, 1);
        chk("rst_psel",    bus.o_psel, 0);
        chk("rst_penable", bus.o_penable, 0);
        chk("rst_rsp",     bus.o_rsp_valid, 0);
        chk("rst_paddr",   bus.o_paddr, 0);
        chk("rst_pwdata",  bus.o_pwdata, 0);
        rstn = 1'b1;
        tick();

        // Write to slave 1, zero wait states
        push(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
        idle();
        tick();
        chk("t1_setup_psel",    bus.o_psel, 3'b010);
        chk("t1_setup_penable", bus.o_penable, 0);
        chk("t1_setup_pwrite",  bus.o_pwrite, 1);
        chk("t1_setup_paddr",   bus.o_paddr, 32'h0000_1004);
        chk("t1_setup_pwdata",  bus.o_pwdata, 32'hDEAD_BEEF);
        chk("t1_setup_pstrb",   bus.o_pstrb, 4'hF);
        chk("t1_setup_pprot",   bus.o_pprot, 3'b010);
        chk("t1_setup_rsp",     bus.o_rsp_valid, 0);
        tick();
        chk("t1_acc_psel",      bus.o_psel, 3'b010);
        chk("t1_acc_penable",   bus.o_penable, 1);
        chk("t1_acc_pwdata",    bus.o_pwdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_rsp_valid",     bus.o_rsp_valid, 1);
        chk("t1_rsp_err",       bus.o_rsp_err, 0);
        chk("t1_rsp_data",      bus.o_rsp_data, 0);
        chk("t1_idle_psel",     bus.o_psel, 0);
        chk("t1_idle_paddr",    bus.o_paddr, 0);
        chk("t1_idle_pwdata",   bus.o_pwdata, 0);
        tick();
        chk("t1_rsp_pulse",     bus.o_rsp_valid, 0);

        // Read from slave 2 with 3 wait states; write data/strobe must not leak
        push(32'h0000_2000, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000);
        idle();
        tick();
        chk("t2_setup_psel",   bus.o_psel, 3'b100);
        chk("t2_setup_pwrite", bus.o_pwrite, 0);
        chk("t2_setup_pstrb",  bus.o_pstrb, 0);
        chk("t2_setup_pwdata", bus.o_pwdata, 0);
        pen = 0;
        for (int i = 0; i < 20 && !bus.o_rsp_valid; i++) begin
            tick();
            if (bus.o_penable) pen++;
        end
        chk("t2_penable_cycles", pen, 4);
        chk("t2_rsp_valid",      bus.o_rsp_valid, 1);
        chk("t2_rsp_data",       bus.o_rsp_data, 32'h1234_5678);
        chk("t2_rsp_err",        bus.o_rsp_err, 0);

        // Index 3 with three slaves: decode error, no select
        push(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'b000);
        idle();
        tick();
        chk("t3_psel",    bus.o_psel, 0);
        chk("t3_penable", bus.o_penable, 0);
        chk("t3_paddr",   bus.o_paddr, 0);
        tick();
        chk("t3_rsp_valid", bus.o_rsp_valid, 1);
        chk("t3_rsp_err",   bus.o_rsp_err, 1);
        chk("t3_rsp_tmo",   bus.o_rsp_timeout, 0);
        chk("t3_rsp_data",  bus.o_rsp_data, 0);
        tick();

        // Slave 0 never ready: 4 counted wait cycles, then ends in the 5th; next command follows
        wait_cfg[0] = -1;
        push(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
        push(32'h0000_1008, 1'b1, 32'h55AA_55AA, 4'b0011, 3'b001);
        idle();
        pen = 0;
        for (int i = 0; i < 20 && !bus.o_rsp_valid; i++) begin
            tick();
            if (bus.o_penable) pen++;
        end
        chk("t4_penable_cycles", pen, 5);
        chk("t4_rsp_valid",      bus.o_rsp_valid, 1);
        chk("t4_rsp_err",        bus.o_rsp_err, 1);
        chk("t4_rsp_tmo",        bus.o_rsp_timeout, 1);
        chk("t4_rsp_data",       bus.o_rsp_data, 0);
        chk("t4_next_psel",      bus.o_psel, 3'b010);
        chk("t4_next_paddr",     bus.o_paddr, 32'h0000_1008);
        chk("t4_next_pstrb",     bus.o_pstrb, 4'b0011);
        wait_cfg[0] = 0;
        tick();
        chk("t4_next_penable",   bus.o_penable, 1);
        tick();
        chk("t4_next_rsp_valid", bus.o_rsp_valid, 1);
        chk("t4_next_rsp_err",   bus.o_rsp_err, 0);
        chk("t4_next_rsp_tmo",   bus.o_rsp_timeout, 0);
        tick();

        // Five back-to-back commands; the first stalls 3 waits so the FIFO fills
        err_cfg[1] = 1'b1;
        rsp_q.delete();
        setup_q.delete();
        push(32'h0000_2010, 1'b0, 32'h0, 4'h0, 3'b000);
        push(32'h0000_0020, 1'b1, 32'h1111_1111, 4'hF, 3'b000);
        push(32'h0000_1030, 1'b1, 32'h2222_2222, 4'hF, 3'b000);
        push(32'h0000_0044, 1'b0, 32'h0, 4'h0, 3'b000);
        push(32'h0000_0058, 1'b1, 32'h3333_3333, 4'hF, 3'b000);
        chk("t5_ready_full", bus.o_ready, 0);
        idle();
        for (int i = 0; i < 60 && rsp_q.size() < 5; i++) tick();
        chk("t5_rsp_count",   rsp_q.size(), 5);
        chk("t5_setup_count", setup_q.size(), 5);
        exp_data = '{32'h1234_5678, 32'h0, 32'h0, 32'hAAAA_0000, 32'h0};
        exp_err  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_gap  = '{5, 2, 2, 2};
        for (int k = 0; k < 5; k++) begin
            if (k < rsp_q.size()) begin
                chk($sformatf("t5_rsp%0d_data", k), rsp_q[k].data, exp_data[k]);
                chk($sformatf("t5_rsp%0d_err", k),  rsp_q[k].err,  exp_err[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k + 1 < setup_q.size())
                chk($sformatf("t5_setup_gap%0d", k), setup_q[k+1] - setup_q[k], exp_gap[k]);
        end
        chk("t5_ready_after", bus.o_ready, 1);
        err_cfg[1] = 1'b0;

        // Reset during ACCESS with two commands queued
        wait_cfg[0] = -1;
        push(32'h0000_0060, 1'b0, 32'h0, 4'h0, 3'b000);
        push(32'h0000_1000, 1'b1, 32'h4444_4444, 4'hF, 3'b000);
        push(32'h0000_0064, 1'b0, 32'h0, 4'h0, 3'b000);
        idle();
        tick();
        chk("t6_pre_penable", bus.o_penable, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_psel",    bus.o_psel, 0);
        chk("t6_async_penable", bus.o_penable, 0);
        chk("t6_async_ready",   bus.o_ready, 1);
        rsp_q.delete();
        setup_q.delete();
        wait_cfg[0] = 0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_rsp",   rsp_q.size(), 0);
        chk("t6_no_setup", setup_q.size(), 0);
        chk("t6_ready",    bus.o_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
